// File: rtl/alu_exec.sv
// alu_exec: execute stage of the 8-bit core.
// Captures two register-file operands, performs the selected operation and
// returns the result plus destination selector for write-back. MUL/DIV/MOD
// run on an iterative datapath, one bit per cycle. A {Z,N,C,V} flags register
// is kept for the branch unit.
module alu_exec #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [2:0]       dest_sel,
  output logic             busy,
  output logic             wb_en,
  output logic [2:0]       wb_dest,
  output logic [WIDTH-1:0] wb_data,
  output logic [3:0]       flags,
  output logic             illegal_op
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_DIV = 4'h9;
  localparam logic [3:0] OP_MOD = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;

  typedef enum logic [1:0] {IDLE, ITER, WB} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        bit_idx;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2:0]           dest_q;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     res_q;
  logic                 c_q, v_q;
  logic                 accept, op_illegal, op_multi, last_step;
  logic [WIDTH+1:0]     single;   // {C, V, result} of a one-cycle op
  logic [WIDTH+1:0]     multi;    // {C, V, result} after the final iteration

  // One-cycle ALU ops; returns {C, V, result}.
  function automatic logic [WIDTH+1:0] alu_single(input logic [3:0]       o,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] r;
    logic             c, v;
    ext = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (o)
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        // Bit WIDTH of the extended difference is the borrow (A < B).
        ext = {1'b0, a} - {1'b0, b};
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: begin
        r = {a[WIDTH-2:0], 1'b0};
        c = a[WIDTH-1];
      end
      OP_SHR: begin
        r = {1'b0, a[WIDTH-1:1]};
        c = a[0];
      end
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  assign accept     = start && (state_q == IDLE);
  assign op_illegal = (op >= 4'hC);
  assign op_multi   = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  assign last_step  = (count_q == CW'(WIDTH - 1));
  assign bit_idx    = CW'(WIDTH - 1) - count_q;
  assign single     = alu_single(op, src1, src2);
  assign busy       = (state_q != IDLE);
  assign wb_en      = (state_q == WB) && (op_q != OP_CMP);

  // Next state: one-cycle ops go straight to WB, MUL/DIV/MOD iterate first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !op_illegal) state_d = op_multi ? ITER : WB;
      ITER: if (last_step) state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration step: shift-add for MUL, restoring subtract for DIV/MOD.
  // A zero divisor needs no special case: every step subtracts, giving an
  // all-ones quotient and the dividend as remainder.
  always_comb begin
    prod_d = prod_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    rem_sh = {rem_q, a_q[bit_idx]};
    if (op_q == OP_MUL) begin
      if (b_q[count_q]) prod_d = prod_q + ({{WIDTH{1'b0}}, a_q} << count_q);
    end else if (rem_sh >= {1'b0, b_q}) begin
      rem_d = WIDTH'(rem_sh - {1'b0, b_q});
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Final result and flag inputs of the iterative ops.
  always_comb begin
    multi = '0;
    case (op_q)
      OP_MUL:  multi = {(prod_d[2*WIDTH-1:WIDTH] != '0), 1'b0, prod_d[WIDTH-1:0]};
      OP_DIV:  multi = {1'b0, (b_q == '0), quo_d};
      default: multi = {1'b0, (b_q == '0), rem_d};
    endcase
  end

  // Control state and architecturally visible outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wb_dest    <= '0;
      wb_data    <= '0;
      flags      <= '0;
      illegal_op <= 1'b0;
    end else begin
      state_q    <= state_d;
      illegal_op <= accept && op_illegal;
      if (accept) begin
        count_q <= '0;
      end else if (state_q == ITER) begin
        count_q <= count_q + CW'(1);
      end
      if (accept && !op_illegal && !op_multi && (op != OP_CMP)) begin
        wb_data <= single[WIDTH-1:0];
        wb_dest <= dest_sel;
      end else if ((state_q == ITER) && last_step) begin
        wb_data <= multi[WIDTH-1:0];
        wb_dest <= dest_q;
      end
      if (state_q == WB) flags <= {(res_q == '0), res_q[WIDTH-1], c_q, v_q};
    end
  end

  // Operand capture and iterative datapath registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q               <= op;
      a_q                <= src1;
      b_q                <= src2;
      dest_q             <= dest_sel;
      {c_q, v_q, res_q}  <= single;
      prod_q             <= '0;
      rem_q              <= '0;
      quo_q              <= '0;
    end else if (state_q == ITER) begin
      prod_q <= prod_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      if (last_step) {c_q, v_q, res_q} <= multi;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Testbench for alu_exec: behavioural model with per-cycle comparison,
// directed test-plan cases and randomized operation sequences.
module tb_alu_exec;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] op = '0;
  logic [7:0] src1 = '0;
  logic [7:0] src2 = '0;
  logic [2:0] dest_sel = '0;
  logic       busy, wb_en, illegal_op;
  logic [2:0] wb_dest;
  logic [7:0] wb_data;
  logic [3:0] flags;

  int total = 0;
  int bad = 0;

  // Model state, in cycle numbers (cyc = index of the latest rising edge).
  int cyc = 0;
  int busy_end = -10;
  int wb_int = -10;
  int flags_at = -10;
  int illegal_int = -10;
  int exp_data = 0, exp_dest = 0, last_data = 0, last_dest = 0;
  int cur_flags = 0, new_flags = 0;
  int wb_count = 0, ill_count = 0, got_data = 0, got_dest = 0;

  alu_exec #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .dest_sel(dest_sel), .busy(busy), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_data(wb_data), .flags(flags), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result of one operation, from plain integer arithmetic.
  function automatic void model(input int o, input int a, input int b,
                                output int res, output int c, output int v, output int wb);
    int sa, sb, s;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    res = 0; c = 0; v = 0; wb = 1;
    case (o)
      0: begin s = a + b; res = s % 256; c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      1, 11: begin
        res = (a - b + 256) % 256; c = (a < b);
        v = (sa - sb > 127) || (sa - sb < -128); wb = (o != 11);
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 255 - a;
      6: begin res = (a * 2) % 256; c = (a >= 128); end
      7: begin res = a / 2; c = a % 2; end
      8: begin s = a * b; res = s % 256; c = (s > 255); end
      9: begin res = (b == 0) ? 255 : a / b; v = (b == 0); end
      10: begin res = (b == 0) ? a : a % b; v = (b == 0); end
      default: wb = 0;
    endcase
  endfunction

  // Model update on each rising edge, then comparison of every output.
  always @(posedge clk) begin : model_p
    int r, c, v, w, lat;
    cyc++;
    if (!reset) begin
      busy_end = -10; wb_int = -10; flags_at = -10; illegal_int = -10;
      last_data = 0; last_dest = 0; cur_flags = 0;
    end else begin
      if (cyc == flags_at) cur_flags = new_flags;
      if (start && (cyc - 1 > busy_end)) begin
        model(op, src1, src2, r, c, v, w);
        if (op >= 12) begin
          illegal_int = cyc;
        end else begin
          lat = (op >= 8 && op <= 10) ? 9 : 1;
          busy_end  = cyc + lat - 1;
          flags_at  = cyc + lat;
          new_flags = (r == 0) * 8 + (r >= 128) * 4 + c * 2 + v;
          if (w != 0) begin
            wb_int = cyc + lat - 1; exp_data = r; exp_dest = dest_sel;
          end
        end
      end
      if (cyc == wb_int) begin last_data = exp_data; last_dest = exp_dest; end
    end
    #1;
    chk("busy", busy, cyc <= busy_end);
    chk("wb_en", wb_en, cyc == wb_int);
    chk("wb_data", wb_data, last_data);
    chk("wb_dest", wb_dest, last_dest);
    chk("flags", flags, cur_flags);
    chk("illegal_op", illegal_op, cyc == illegal_int);
    if (wb_en) begin wb_count++; got_data = wb_data; got_dest = wb_dest; end
    if (illegal_op) ill_count++;
  end

  // Issue one op from a falling edge and wait until the block is idle again.
  // With poke set, a stray start is driven so that it lands on edge T+3.
  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] d, input bit poke, output int bc);
    int k;
    op = o; src1 = a; src2 = b; dest_sel = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bc = 0; k = 0;
    while (busy && k < 40) begin
      bc++; k++;
      if (poke && bc == 3) begin
        start = 1'b1; op = 4'($urandom_range(0, 11));
        src1 = 8'($urandom); src2 = 8'($urandom); dest_sel = 3'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("busy_bounded", (k >= 40), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, w0, i0, r, c, v, w;
    logic [3:0] ro;
    logic [7:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_flags", flags, 0);
    chk("rst_illegal", illegal_op, 0);
    reset = 1'b1;
    @(negedge clk);

    // Pin the model against hand-computed values.
    model(0, 127, 1, r, c, v, w);  chk("model_add_res", r, 8'h80); chk("model_add_v", v, 1);
    model(9, 200, 7, r, c, v, w);  chk("model_div", r, 8'h1C);
    model(10, 200, 7, r, c, v, w); chk("model_mod", r, 8'h04);
    model(8, 12, 11, r, c, v, w);  chk("model_mul", r, 8'h84); chk("model_mul_c", c, 0);
    model(11, 3, 4, r, c, v, w);   chk("model_cmp_c", c, 1); chk("model_cmp_wb", w, 0);

    w0 = wb_count;
    issue(4'h0, 8'h7F, 8'h01, 3'd3, 1'b0, bc);
    chk("add_data", got_data, 8'h80); chk("add_dest", got_dest, 3);
    chk("add_flags", flags, 4'b0101); chk("add_wb_count", wb_count - w0, 1);

    issue(4'h1, 8'h05, 8'h05, 3'd1, 1'b0, bc);
    chk("sub_data", got_data, 8'h00); chk("sub_flags", flags, 4'b1000);

    w0 = wb_count;
    issue(4'hB, 8'h03, 8'h04, 3'd2, 1'b0, bc);
    chk("cmp_no_wb", wb_count - w0, 0); chk("cmp_flags", flags, 4'b0110);

    issue(4'h8, 8'h10, 8'h20, 3'd4, 1'b0, bc);
    chk("mul_busy_cycles", bc, 9); chk("mul_data", got_data, 8'h00);
    chk("mul_flags", flags, 4'b1010);

    issue(4'h8, 8'h0C, 8'h0B, 3'd4, 1'b0, bc);
    chk("mul2_data", got_data, 8'h84); chk("mul2_flags", flags, 4'b0100);

    issue(4'h9, 8'd200, 8'd7, 3'd5, 1'b0, bc);
    chk("div_data", got_data, 8'h1C); chk("div_flags", flags, 4'b0000);
    issue(4'hA, 8'd200, 8'd7, 3'd5, 1'b0, bc);
    chk("mod_data", got_data, 8'h04);
    issue(4'h9, 8'h2A, 8'h00, 3'd6, 1'b0, bc);
    chk("div0_data", got_data, 8'hFF); chk("div0_flags", flags, 4'b0101);
    issue(4'hA, 8'h2A, 8'h00, 3'd6, 1'b0, bc);
    chk("mod0_data", got_data, 8'h2A); chk("mod0_flags", flags, 4'b0001);

    w0 = wb_count; i0 = ill_count;
    issue(4'hE, 8'h12, 8'h34, 3'd7, 1'b0, bc);
    @(negedge clk);
    chk("illegal_pulses", ill_count - i0, 1); chk("illegal_no_wb", wb_count - w0, 0);
    chk("illegal_flags_kept", flags, 4'b0001);

    w0 = wb_count;
    issue(4'h9, 8'd200, 8'd7, 3'd5, 1'b1, bc);
    chk("poke_one_wb", wb_count - w0, 1); chk("poke_data", got_data, 8'h1C);
    chk("poke_dest", got_dest, 5);

    // Reset in the middle of a MUL.
    issue(4'h0, 8'h7F, 8'h01, 3'd3, 1'b0, bc);
    w0 = wb_count;
    op = 4'h8; src1 = 8'h33; src2 = 8'h44; dest_sel = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0); chk("midrst_flags", flags, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (9) @(negedge clk);
    chk("midrst_no_wb", wb_count - w0, 0);
    issue(4'h0, 8'h11, 8'h22, 3'd7, 1'b0, bc);
    chk("after_rst_data", got_data, 8'h33); chk("after_rst_dest", got_dest, 7);
    chk("after_rst_flags", flags, 4'b0000);

    // Randomized sequences, checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      issue(ro, ra, rb, 3'($urandom), ($urandom_range(0, 3) == 0), bc);
    end
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage of the 8-bit core, directly downstream of the general register file. It captures the two operands read from the register file (`src1`, `src2`), performs the selected ALU operation, and returns the result and destination selector for write-back into the register file. Single-cycle ops complete in one cycle. MUL, DIV and MOD use an 8-iteration sequential datapath. A 4-bit flags register is maintained for the branch unit.

## Interface
- `WIDTH`, default 8: operand and result width. Only 8 is supported; the iteration count equals `WIDTH`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request; accepted only when `busy`=0.
- `op` input 4: opcode, sampled with `start`.
- `src1` input 8: operand A from the register file, sampled with `start`.
- `src2` input 8: operand B from the register file, sampled with `start`.
- `dest_sel` input 3: destination register R0–R7, sampled with `start`.
- `busy` output 1: high from the cycle after accept through the write-back cycle.
- `wb_en` output 1: one-cycle write-back strobe. The top level qualifies the register-file latch with it.
- `wb_dest` output 3: destination selector, valid when `wb_en`=1.
- `wb_data` output 8: result, valid when `wb_en`=1.
- `flags` output 4: registered {Z,N,C,V}.
- `illegal_op` output 1: one-cycle pulse for an undefined opcode.

## Operation
- **Opcodes:**
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR.
  - 5 NOT (~A), 6 SHL (A<<1), 7 SHR (logical A>>1).
  - 8 MUL (low byte of A×B), 9 DIV (A/B unsigned quotient), A MOD (A%B unsigned remainder).
  - B CMP (A−B, flags only).
  - C–F are illegal.
- **Operand capture:** operands, `op` and `dest_sel` are registered at accept. Later changes on the inputs do not affect an operation in progress.
- **State machine:** IDLE, ITER, WB.
  - IDLE + `start`, op in {0–7, B}: compute the result combinationally from the captured inputs, register it, go to WB.
  - IDLE + `start`, op in {8, 9, A}: load the datapath, set count=0, go to ITER.
  - IDLE + `start`, illegal op: pulse `illegal_op` next cycle. Stay IDLE; no `wb_en`, flags unchanged.
  - ITER: one shift-add (MUL) or one restoring-subtract step (DIV/MOD) per cycle. After the count=7 step, go to WB.
  - WB: `wb_en`=1 for op≠B (CMP gives `wb_en`=0). Flags are updated. Next state is IDLE.
- **MUL:** 16-bit internal product. `wb_data` = product[7:0]. C = (product[15:8] ≠ 0).
- **DIV/MOD by zero:** quotient = 0xFF, remainder = A, V=1.
- **Flags, for all write-back ops and CMP:**
  - Z = (result == 0). N = result[7].
  - C:
    - ADD: carry-out.
    - SUB/CMP: borrow (A<B).
    - SHL: old A[7]. SHR: old A[0].
    - MUL: as defined above.
    - All other ops: 0.
  - V:
    - ADD/SUB/CMP: signed overflow.
    - DIV/MOD: divide-by-zero.
    - All other ops: 0.
- **`start` while busy:** ignored, with no queueing.

## Timing
- **Reset values:** `busy`=0, `wb_en`=0, `wb_dest`=0, `wb_data`=0x00, `flags`=0x0, `illegal_op`=0, state IDLE, count 0.
- **Single-cycle ops:** `start` sampled at edge T. `busy`=1 and `wb_en`=1 in cycle T+1. Back in IDLE at T+2, so the next `start` can be accepted at edge T+2.
- **MUL/DIV/MOD:** accepted at edge T. ITER during cycles T+1..T+8. `wb_en`=1 in cycle T+9. `busy`=1 for 9 cycles.
- **Flags register:** changes at the edge ending the WB cycle, i.e. the flags are visible in the cycle after `wb_en`.
- **Outputs:** `wb_data` and `wb_dest` hold their last values outside WB. `wb_en` is never high for two consecutive cycles.
- **Reset mid-operation:** asserting `reset` low in any state aborts immediately. No `wb_en` follows, and flags are cleared.

## Test plan
- ADD 0x7F+0x01, dest R3 -> cycle T+1: `wb_en`=1, `wb_dest`=3, `wb_data`=0x80. Flags next cycle: Z=0, N=1, C=0, V=1.
- SUB 0x05−0x05, then CMP 0x03−0x04 -> first op: `wb_data`=0x00, flags Z=1, C=0. CMP: no `wb_en`, flags N=1, C=1, Z=0.
- MUL 0x10×0x20 -> `busy` high for 9 cycles, `wb_en` at T+9, `wb_data`=0x00, flags Z=1, C=1. MUL 0x0C×0x0B -> 0x84, C=0.
- DIV 200/7 -> 0x1C. MOD 200/7 -> 0x04. DIV 0x2A/0 -> 0xFF with V=1. MOD 0x2A/0 -> 0x2A.
- `start` pulsed at T+3 during a DIV -> ignored; exactly one `wb_en`, result unaffected. op=0xE -> `illegal_op` pulse, no `wb_en`, flags unchanged.
- `reset` low at T+4 of a MUL -> `busy`=0 and `flags`=0 immediately. No `wb_en` through T+12. A new ADD after release completes normally.
